// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Splits a 0..31 shift into passes of at most 15 through an
//            external combinational shifter and reports the result with flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_data,
  input  logic [4:0]  req_amt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_cond,
  output logic [15:0] sh_a,
  output logic [3:0]  sh_opcode,
  output logic [3:0]  sh_d,
  input  logic [15:0] sh_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_work;
  logic [1:0]  r_op;
  logic [4:0]  r_rem;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic [3:0]  r_rsp_cond;

  logic [3:0]  w_d;
  logic [4:0]  w_rem_next;
  logic [3:0]  w_idx_left;
  logic [3:0]  w_idx_right;
  logic        w_carry;
  logic        w_in_pass;

  assign w_in_pass  = (r_state == ST_PASS);
  assign w_d        = (r_rem > 5'd15) ? 4'd15 : r_rem[3:0];
  assign w_rem_next = r_rem - {1'b0, w_d};

  // Modulo-16 arithmetic gives 16-d and d-1 for d in 1..15.
  assign w_idx_left  = 4'd0 - w_d;
  assign w_idx_right = w_d - 4'd1;

  always_comb begin
    w_carry = 1'b0;
    if (w_d != 4'd0) begin
      case (r_op)
        2'b00:   w_carry = r_work[w_idx_left];
        2'b10,
        2'b11:   w_carry = r_work[w_idx_right];
        default: w_carry = 1'b0;
      endcase
    end
  end

  assign sh_a      = w_in_pass ? r_work : 16'h0000;
  assign sh_opcode = w_in_pass ? {2'b10, r_op} : 4'd0;
  assign sh_d      = w_in_pass ? w_d : 4'd0;

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_cond  = r_rsp_cond;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_cond  <= 4'b0000;
      r_work      <= 16'h0000;
      r_rem       <= 5'd0;
      r_op        <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_work  <= req_data;
            r_op    <= req_op;
            r_rem   <= req_amt;
            r_state <= ST_PASS;
          end
        end
        ST_PASS: begin
          r_work <= sh_out;
          r_rem  <= w_rem_next;
          if (w_rem_next == 5'd0) begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= sh_out;
            r_rsp_cond  <= {sh_out[15], (sh_out == 16'h0000), w_carry, 1'b0};
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer with a whole-shift model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic [4:0]  req_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_cond;
  logic [15:0] sh_a;
  logic [3:0]  sh_opcode;
  logic [3:0]  sh_d;
  logic [15:0] sh_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cond  (rsp_cond),
    .sh_a      (sh_a),
    .sh_opcode (sh_opcode),
    .sh_d      (sh_d),
    .sh_out    (sh_out),
    .busy      (busy)
  );

  // Whole shift of a by n (0..31) in one step: used both as the external
  // shifter and as the reference for the multi-pass result.
  function automatic logic [15:0] shift_total(input logic [1:0] op, input logic [15:0] a, input int n);
    logic [31:0]        t;
    logic signed [31:0] s;
    case (op)
      2'd0: begin t = {16'h0000, a} << n; return t[15:0]; end
      2'd1: begin t = {a, a} << (n % 16); return t[31:16]; end
      2'd2: begin t = {16'h0000, a} >> n; return t[15:0]; end
      default: begin s = $signed({{16{a[15]}}, a}); s = s >>> n; return s[15:0]; end
    endcase
  endfunction

  assign sh_out = shift_total(sh_opcode[1:0], sh_a, int'(sh_d));

  function automatic int pass_count(input int amt);
    return (amt == 0) ? 1 : (amt + 14) / 15;
  endfunction

  function automatic logic [3:0] ref_cond(input logic [1:0] op, input logic [15:0] a, input int amt);
    logic [15:0] res;
    logic [15:0] w;
    int          dl;
    logic        c;
    res = shift_total(op, a, amt);
    c   = 1'b0;
    if (amt != 0) begin
      dl = ((amt - 1) % 15) + 1;
      w  = shift_total(op, a, amt - dl);
      if (op == 2'd0)      c = w[16 - dl];
      else if (op != 2'd1) c = w[dl - 1];
    end
    return {res[15], (res == 16'h0000), c, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] data, input logic [4:0] amt,
                        input int hold, input logic [15:0] edata, input logic [3:0] econd);
    int guard;
    int consumed;
    int d;
    int passes;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_amt   = amt;
    tick();
    passes   = pass_count(int'(amt));
    consumed = 0;
    for (int k = 0; k < passes; k++) begin
      d = (int'(amt) - consumed > 15) ? 15 : int'(amt) - consumed;
      chk("pass_flags", {29'd0, busy, req_ready, rsp_valid}, {29'd0, 3'b100});
      chk("sh_a", {16'd0, sh_a}, {16'd0, shift_total(op, data, consumed)});
      chk("sh_opcode", {28'd0, sh_opcode}, 32'(8 + int'(op)));
      chk("sh_d", {28'd0, sh_d}, 32'(d));
      consumed += d;
      // Request fields wiggle during the passes and must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 2'($urandom);
      req_data  = 16'($urandom);
      req_amt   = 5'($urandom);
      tick();
    end
    req_valid = 1'b0;
    chk("done_valid", {31'd0, rsp_valid}, 32'd1);
    chk("done_data", {16'd0, rsp_data}, {16'd0, edata});
    chk("done_cond", {28'd0, rsp_cond}, {28'd0, econd});
    chk("done_flags", {30'd0, req_ready, busy}, 32'd1);
    chk("done_sh_idle", {sh_a, sh_opcode, sh_d}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_state", {10'd0, rsp_valid, req_ready, rsp_cond, rsp_data}, {10'd0, 1'b1, 1'b0, econd, edata});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("after_hs_flags", {29'd0, rsp_valid, req_ready, busy}, {29'd0, 3'b010});
    chk("after_hs_held", {12'd0, rsp_cond, rsp_data}, {12'd0, econd, edata});
  endtask

  // Reset after npass pass edges (npass == passes lands in DONE).
  task automatic abort_op(input logic [1:0] op, input logic [15:0] data, input logic [4:0] amt, input int npass);
    logic seen;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_amt   = amt;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < npass; k++) tick();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b0;
    chk("abort_flags", {29'd0, req_ready, rsp_valid, busy}, {29'd0, 3'b100});
    chk("abort_cleared", {12'd0, rsp_cond, rsp_data}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", {31'd0, seen}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [4:0]  amt;
    logic [15:0] edata;
    logic [3:0]  econd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [1:0]  rop;
    logic [15:0] rdata;
    logic [4:0]  ramt;

    vecs[0] = '{2'd0, 16'h8001, 5'd1,  16'h0002, 4'b0010};
    vecs[1] = '{2'd3, 16'h8000, 5'd31, 16'hFFFF, 4'b1010};
    vecs[2] = '{2'd1, 16'h1234, 5'd16, 16'h1234, 4'b0000};
    vecs[3] = '{2'd2, 16'h0001, 5'd0,  16'h0001, 4'b0000};
    vecs[4] = '{2'd2, 16'h0001, 5'd1,  16'h0000, 4'b0110};
    vecs[5] = '{2'd0, 16'h00FF, 5'd15, 16'h8000, 4'b1010};
    vecs[6] = '{2'd2, 16'hF000, 5'd20, 16'h0000, 4'b0100};

    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_data  = 16'hFFFF;
    req_amt   = 5'd3;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    req_valid = 1'b0;
    chk("reset_flags", {29'd0, req_ready, busy, rsp_valid}, {29'd0, 3'b100});
    chk("reset_rsp", {12'd0, rsp_cond, rsp_data}, 32'd0);
    chk("reset_sh", {sh_a, sh_opcode, sh_d}, 32'd0);

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].op, vecs[i].data, vecs[i].amt, (i == 1) ? 3 : 0, vecs[i].edata, vecs[i].econd);

    // Reset during the second pass of an amt-20 request, then in DONE.
    abort_op(2'd0, 16'hABCD, 5'd20, 1);
    abort_op(2'd3, 16'h8421, 5'd1, 1);

    for (int i = 0; i < 40; i++) begin
      rop   = 2'($urandom);
      rdata = 16'($urandom);
      ramt  = (i < 4) ? 5'(i * 10) : 5'($urandom);
      run_op(rop, rdata, ramt, $urandom_range(0, 2),
             shift_total(rop, rdata, int'(ramt)), ref_cond(rop, rdata, int'(ramt)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: req_valid  in  1  request present.
REQ-004 SHALL have ports: req_ready  out  1  sequencer can accept.
REQ-005 SHALL have ports: req_op  in  2  00 SLL, 01 SLR (rotate left), 10 SRL, 11 SRA.
REQ-006 SHALL have ports: req_data  in  16  operand.
REQ-007 SHALL have ports: req_amt  in  5  shift amount, 0..31.
REQ-008 SHALL have ports: rsp_valid  out  1  result present.
REQ-009 SHALL have ports: rsp_ready  in  1  consumer accepts.
REQ-010 SHALL have ports: rsp_data  out  16  result.
REQ-011 SHALL have ports: rsp_cond  out  4  {S,Z,C,V}, with S at bit 3 and V at bit 0.
REQ-012 SHALL have ports: sh_a  out  16  operand to the external shifter.
REQ-013 SHALL have ports: sh_opcode  out  4  shifter opcode, 8..11.
REQ-014 SHALL have ports: sh_d  out  4  per-pass amount, 0..15.
REQ-015 SHALL have ports: sh_out  in  16  combinational shifter result.
REQ-016 SHALL have ports: busy  out  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, PASS, DONE.
REQ-018 SHALL drive req_ready high only in IDLE.
REQ-019 SHALL accept a request on a clock edge where req_valid and req_ready are both high.
REQ-020 On acceptance, SHALL latch work=req_data, op=req_op, rem=req_amt, and go to PASS.
REQ-021 In PASS, SHALL drive sh_a=work, sh_opcode=8+op, sh_d=min(rem,15).
REQ-022 In PASS, SHALL register work<=sh_out and rem<=rem-sh_d each cycle.
REQ-023 Pass count SHALL be max(1, ceil(amt/15)): amt 0 gives 1 pass with d=0; amt 31 gives passes of 15, 15, 1.
REQ-024 SHALL go PASS->DONE on the edge where rem-sh_d==0; otherwise SHALL stay in PASS.
REQ-025 Latency: accept at edge t; rsp_valid SHALL be high after edge t+P, where P is the pass count.
REQ-026 At PASS->DONE, SHALL register rsp_data=sh_out and S=sh_out[15].
REQ-027 At PASS->DONE, SHALL register Z=(sh_out==0) and V=0.
REQ-028 C SHALL be computed from the final-pass input w and final d.
REQ-029 C for SLL SHALL be w[16-d].
REQ-030 C for SRL and SRA SHALL be w[d-1].
REQ-031 C for SLR SHALL be 0.
REQ-032 C for amt 0 SHALL be 0.
REQ-033 The sh_out-derived condition output of the shifter SHALL NOT be used.
REQ-034 In DONE, SHALL hold rsp_valid, rsp_data and rsp_cond stable until rsp_ready is high.
REQ-035 On the edge with rsp_valid and rsp_ready, SHALL go to IDLE and drop rsp_valid.
REQ-036 SHALL accept no new request in the DONE cycle, so minimum request spacing is P+2 cycles.
REQ-037 Outside PASS, sh_a, sh_opcode and sh_d SHALL be 0.
REQ-038 req_data, req_op and req_amt SHALL be ignored when not accepted; changes during PASS SHALL have no effect.
REQ-039 rsp_data and rsp_cond SHALL hold their last values after the handshake until the next DONE.

Reset
REQ-040 When rst is high at an edge, SHALL set state=IDLE and rsp_valid=0.
REQ-041 On reset, SHALL set rsp_data=0x0000, rsp_cond=0000, work=0, rem=0, and op=0.
REQ-042 On reset, req_ready SHALL be high and busy low in the following cycle.
REQ-043 rst SHALL override any concurrent request acceptance or response handshake.
REQ-044 Reset during PASS or DONE SHALL abort the operation, which SHALL never produce rsp_valid.

Verification
REQ-045 SLL 0x8001 amt 1 SHALL give 1 pass, d=1; rsp_data=0x0002 and rsp_cond=0010 at cycle t+1.
REQ-046 SRA 0x8000 amt 31 SHALL give sh_d sequence 15, 15, 1; rsp_data=0xFFFF and rsp_cond=1010 at cycle t+3.
REQ-047 SLR 0x1234 amt 16 SHALL give passes 15, 1; rsp_data=0x1234 and rsp_cond=0000.
REQ-048 SRL 0x0001 amt 0 SHALL give 1 pass with d=0, rsp_data=0x0001 and rsp_cond=0000.
REQ-049 SRL 0x0001 amt 1 SHALL give rsp_data=0x0000 and rsp_cond=0110.
REQ-050 With rsp_ready low for 3 cycles in DONE, rsp_valid, rsp_data and rsp_cond SHALL stay stable and req_ready SHALL stay 0; IDLE SHALL follow the handshake edge.
REQ-051 rst during the second pass of an amt-20 request SHALL give IDLE, req_ready=1 and rsp_valid=0 next cycle, and no response SHALL ever appear.
